// File: rtl/date_key_pulser.sv
// Front-panel key conditioner: sync + debounce, up/down pulses, edit toggle.
// Optional auto-repeat built when KEY_AUTOREPEAT_EN is defined.
//
// Ports:
//   clk      in  system clock, all logic on posedge
//   reset    in  synchronous active-low reset
//   btn_up   in  raw up key (async, active-high)
//   btn_down in  raw down key (async, active-high)
//   btn_edit in  raw edit-mode key (async, active-high)
//   up       out one-clock increment pulse
//   down     out one-clock decrement pulse
//   enable   out 1 = edit mode, 0 = counters follow RTC
//   busy     out key FSM not in IDLE
module date_key_pulser #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_edit,
  output logic up,
  output logic down,
  output logic enable,
  output logic busy
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK
  } state_e;

  // key index: 0 = up, 1 = down, 2 = edit
  logic [2:0] raw;
  logic [2:0] s1_q;
  logic [2:0] s2_q;
  logic [2:0] lvl_q;
  logic [2:0] lvl_d;
  logic [2:0] prev_q;
  logic [2:0] rise;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];

  logic   en_q;
  logic   en_d;
  state_e state_q;
  state_e state_d;
  logic   key_q;
  logic   key_d;
  logic   up_q;
  logic   up_d;
  logic   down_q;
  logic   down_d;
  logic   held;
  logic   other;

  assign raw  = {btn_edit, btn_down, btn_up};
  assign rise = lvl_q & ~prev_q;

  // Counter only runs while the synced level disagrees with the
  // debounced one; any agreeing cycle restarts the count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      lvl_q  <= '0;
      prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign en_d = en_q ^ rise[2];

  // key_q: 1 = up is the key being serviced, 0 = down
  assign held  = key_q ? lvl_q[0] : lvl_q[1];
  assign other = key_q ? lvl_q[1] : lvl_q[0];

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned TMAX =
    (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned TW = $clog2(TMAX);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYC - 1);

  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic [TW-1:0] tmr_last;

  assign tmr_last = (state_q == HOLD) ? HOLD_LAST : REP_LAST;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  // Hold/repeat timing has no effect without auto-repeat.
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYC, REPEAT_CYC};
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    tmr_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise[0] && !lvl_q[1] && en_q) begin
          up_d    = 1'b1;
          key_d   = 1'b1;
          state_d = HOLD;
        end else if (rise[1] && !lvl_q[0] && en_q) begin
          down_d  = 1'b1;
          key_d   = 1'b0;
          state_d = HOLD;
        end else if (lvl_q[0] || lvl_q[1]) begin
          state_d = LOCK;
        end
      end
      HOLD, REPEAT: begin
        // Release beats lock, lock beats timer expiry.
        if (!held) begin
          state_d = IDLE;
        end else if (other || !en_q) begin
          state_d = LOCK;
`ifdef KEY_AUTOREPEAT_EN
        end else if (tmr_q == tmr_last) begin
          up_d    = key_q;
          down_d  = ~key_q;
          state_d = REPEAT;
        end else begin
          tmr_d = tmr_q + TW'(1);
`endif
        end
      end
      LOCK: begin
        if (!lvl_q[0] && !lvl_q[1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      up_q    <= up_d;
      down_q  <= down_d;
      en_q    <= en_d;
    end
  end

  assign up     = up_q;
  assign down   = down_q;
  assign enable = en_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_date_key_pulser.sv
// Directed bench for date_key_pulser.
// DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5.
module tb_date_key_pulser;

  logic clk;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic btn_edit;
  logic up;
  logic down;
  logic enable;
  logic busy;

  int cmp_n;
  int err_n;
  int up_hits[$];
  int dn_hits[$];
  int busy_cnt;
  int both_cnt;
  int en_rise;
  int en_fall;
  int en_first;
  logic en_prev;

`ifdef KEY_AUTOREPEAT_EN
  localparam string EXP_DN5 = "7,27,32,37,42,47,52,57,62,";
  localparam string EXP_UPB = "7,27,32,37,42,";
  localparam string EXP_UPE = "7,27,32,37,";
`else
  localparam string EXP_DN5 = "7,";
  localparam string EXP_UPB = "7,";
  localparam string EXP_UPE = "7,";
`endif

  date_key_pulser #(
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (20),
    .REPEAT_CYC  (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_edit(btn_edit),
    .up      (up),
    .down    (down),
    .enable  (enable),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear();
    up_hits.delete();
    dn_hits.delete();
    busy_cnt = 0;
    both_cnt = 0;
    en_rise  = 0;
    en_fall  = 0;
    en_first = 0;
    en_prev  = enable;
  endtask

  // k counts negedges after the stimulus negedge.
  task automatic watch(input int k);
    @(negedge clk);
    if (up) up_hits.push_back(k);
    if (down) dn_hits.push_back(k);
    if (up && down) both_cnt++;
    if (busy) busy_cnt++;
    if (enable && !en_prev) begin
      en_rise++;
      if (en_first == 0) en_first = k;
    end
    if (!enable && en_prev) en_fall++;
    en_prev = enable;
  endtask

  function automatic string hits(input bit dn);
    string s;
    s = "";
    if (dn) begin
      foreach (dn_hits[i]) s = {s, $sformatf("%0d,", dn_hits[i])};
    end else begin
      foreach (up_hits[i]) s = {s, $sformatf("%0d,", up_hits[i])};
    end
    return s;
  endfunction

  task automatic test_reset();
    logic [3:0] o;
    reset    = 1'b0;
    btn_up   = 1'b1;
    btn_down = 1'b0;
    btn_edit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = {up, down, busy, enable};
      cmp_n++;
      if (o !== 4'b0) begin
        $display("FAIL reset_hold[%0d]: got %b want 0000", i, o);
        err_n++;
      end
      btn_up   = ~btn_up;
      btn_down = ~btn_down;
      btn_edit = ~btn_edit;
    end
    reset    = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_edit = 1'b0;
    @(negedge clk);
    o = {up, down, busy, enable};
    cmp_n++;
    if (o !== 4'b0) begin
      $display("FAIL reset_after: got %b want 0000", o);
      err_n++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic press_edit(input int rel_k, input int n);
    clear();
    btn_edit = 1'b1;
    for (int k = 1; k <= n; k++) begin
      watch(k);
      if (k == rel_k) btn_edit = 1'b0;
    end
  endtask

  task automatic test_edit();
    press_edit(10, 20);
    cmp_n++;
    if (en_rise !== 1 || en_fall !== 0) begin
      $display("FAIL edit_on: got rise=%0d fall=%0d want 1/0",
               en_rise, en_fall);
      err_n++;
    end
    cmp_n++;
    if (en_first !== 7) begin
      $display("FAIL edit_lat: got %0d want 7", en_first);
      err_n++;
    end
    press_edit(10, 20);
    cmp_n++;
    if (en_rise !== 0 || en_fall !== 1 || enable !== 1'b0) begin
      $display("FAIL edit_off: got rise=%0d fall=%0d en=%b want 0/1/0",
               en_rise, en_fall, enable);
      err_n++;
    end
    press_edit(10, 20);
    cmp_n++;
    if (enable !== 1'b1) begin
      $display("FAIL edit_restore: got %b want 1", enable);
      err_n++;
    end
  endtask

  task automatic test_short();
    clear();
    btn_up = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      watch(k);
      if (k == 3) btn_up = 1'b0;
    end
    cmp_n++;
    if (hits(0) != "" || busy_cnt !== 0) begin
      $display("FAIL short: got up='%s' busy=%0d want ''/0",
               hits(0), busy_cnt);
      err_n++;
    end
  endtask

  task automatic test_single();
    clear();
    btn_up = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      watch(k);
      if (k == 12) btn_up = 1'b0;
    end
    cmp_n++;
    if (hits(0) != "7,") begin
      $display("FAIL single_up: got '%s' want '7,'", hits(0));
      err_n++;
    end
    cmp_n++;
    if (hits(1) != "" || busy !== 1'b0) begin
      $display("FAIL single_idle: got dn='%s' busy=%b want ''/0",
               hits(1), busy);
      err_n++;
    end
  endtask

  task automatic test_repeat();
    clear();
    btn_down = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      watch(k);
      if (k == 60) btn_down = 1'b0;
    end
    cmp_n++;
    if (hits(1) != EXP_DN5) begin
      $display("FAIL repeat_dn: got '%s' want '%s'", hits(1), EXP_DN5);
      err_n++;
    end
    cmp_n++;
    if (hits(0) != "" || both_cnt !== 0) begin
      $display("FAIL repeat_up: got '%s' both=%0d want ''/0",
               hits(0), both_cnt);
      err_n++;
    end
    cmp_n++;
    if (busy !== 1'b0) begin
      $display("FAIL repeat_busy: got %b want 0", busy);
      err_n++;
    end
  endtask

  task automatic test_both();
    clear();
    btn_up   = 1'b1;
    btn_down = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      watch(k);
      if (k == 12) begin
        btn_up   = 1'b0;
        btn_down = 1'b0;
      end
    end
    cmp_n++;
    if (hits(0) != "" || hits(1) != "") begin
      $display("FAIL both_pulse: got up='%s' dn='%s' want none",
               hits(0), hits(1));
      err_n++;
    end
    cmp_n++;
    if (busy_cnt == 0 || busy !== 1'b0) begin
      $display("FAIL both_lock: got busy_cnt=%0d busy=%b want >0/0",
               busy_cnt, busy);
      err_n++;
    end
  endtask

  task automatic test_cross();
    clear();
    btn_up = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      watch(k);
      if (k == 40) btn_down = 1'b1;
      if (k == 60) btn_up = 1'b0;
      if (k == 70) btn_down = 1'b0;
    end
    cmp_n++;
    if (hits(0) != EXP_UPB || hits(1) != "") begin
      $display("FAIL cross: got up='%s' dn='%s' want '%s'/''",
               hits(0), hits(1), EXP_UPB);
      err_n++;
    end
    cmp_n++;
    if (busy !== 1'b0) begin
      $display("FAIL cross_busy: got %b want 0", busy);
      err_n++;
    end
  endtask

  task automatic test_disable_mid();
    clear();
    btn_up = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      watch(k);
      if (k == 30) btn_edit = 1'b1;
      if (k == 40) btn_edit = 1'b0;
      if (k == 50) btn_up = 1'b0;
    end
    cmp_n++;
    if (hits(0) != EXP_UPE) begin
      $display("FAIL dis_mid: got '%s' want '%s'", hits(0), EXP_UPE);
      err_n++;
    end
    cmp_n++;
    if (enable !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL dis_mid_end: got en=%b busy=%b want 0/0",
               enable, busy);
      err_n++;
    end
  endtask

  task automatic test_disabled();
    clear();
    btn_up = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      watch(k);
      if (k == 30) btn_up = 1'b0;
    end
    cmp_n++;
    if (hits(0) != "" || hits(1) != "") begin
      $display("FAIL disabled: got up='%s' dn='%s' want none",
               hits(0), hits(1));
      err_n++;
    end
    cmp_n++;
    if (busy_cnt == 0 || busy !== 1'b0) begin
      $display("FAIL disabled_lock: got busy_cnt=%0d busy=%b want >0/0",
               busy_cnt, busy);
      err_n++;
    end
  endtask

  initial begin
    cmp_n    = 0;
    err_n    = 0;
    reset    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_edit = 1'b0;
    test_reset();
    test_edit();
    test_short();
    test_single();
    test_repeat();
    test_both();
    test_cross();
    test_disable_mid();
    test_disabled();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
